// File: rtl/march_bist_engine.sv
// march_bist_engine
//   March-test BIST sequencer for a single-port synchronous SRAM.
//   Runs MATS+, March C- or March LR with a solid or checkerboard data
//   background and records the first failing address/element.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   en_in             start request (level), sampled in IDLE
//   mode_in, bg_in    algorithm / background, latched at start
//   dat_in            SRAM read data (RD_LAT cycles after address)
//   addr_out, dat_out SRAM address / write data (expected value on reads)
//   w_en_out          SRAM write enable
//   busy, rst_done    running / finished status
//   fail, fail_addr,  sticky mismatch flag and first-failure capture
//   fail_elem
module march_bist_engine #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 8,
    parameter int RD_LAT       = 3,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [1:0]        mode_in,
    input  logic              bg_in,
    input  logic [DATA_W-1:0] dat_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] dat_out,
    output logic              w_en_out,
    output logic              busy,
    output logic              rst_done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_OP, S_DONE} state_t;

    // One march element: op count minus one, per-op write flag and data
    // value (0 = background, 1 = inverted background), last-element flag.
    typedef struct packed {
        logic [1:0] nm1;
        logic [3:0] wr;
        logic [3:0] val;
        logic       last;
    } elem_t;

    // Checkerboard pattern for even addresses: bit j = j[0].
    function automatic logic [DATA_W-1:0] chk_pat();
        logic [DATA_W-1:0] p;
        for (int j = 0; j < DATA_W; j++) p[j] = j[0];
        return p;
    endfunction

    localparam logic [DATA_W-1:0] CHK = chk_pat();

    // Element ROM. Element 0 is ⇕(w0) for every algorithm; mode 3 maps to LR.
    function automatic elem_t elem_rom(input logic [1:0] mode, input logic [2:0] idx);
        elem_t e;
        e = '{2'd0, 4'b0001, 4'b0000, 1'b0};
        if (mode == 2'd0) begin
            case (idx)
                3'd1:    e = '{2'd1, 4'b0010, 4'b0010, 1'b0};  // r0,w1
                3'd2:    e = '{2'd1, 4'b0010, 4'b0001, 1'b1};  // r1,w0
                default: ;
            endcase
        end else if (mode == 2'd1) begin
            case (idx)
                3'd1:    e = '{2'd1, 4'b0010, 4'b0010, 1'b0};  // r0,w1
                3'd2:    e = '{2'd1, 4'b0010, 4'b0001, 1'b0};  // r1,w0
                3'd3:    e = '{2'd1, 4'b0010, 4'b0010, 1'b0};  // r0,w1
                3'd4:    e = '{2'd1, 4'b0010, 4'b0001, 1'b0};  // r1,w0
                3'd5:    e = '{2'd0, 4'b0000, 4'b0000, 1'b1};  // r0
                default: ;
            endcase
        end else begin
            case (idx)
                3'd1:    e = '{2'd1, 4'b0010, 4'b0010, 1'b0};  // r0,w1
                3'd2:    e = '{2'd3, 4'b1010, 4'b1001, 1'b0};  // r1,w0,r0,w1
                3'd3:    e = '{2'd1, 4'b0010, 4'b0001, 1'b0};  // r1,w0
                3'd4:    e = '{2'd3, 4'b1010, 4'b0110, 1'b0};  // r0,w1,r1,w0
                3'd5:    e = '{2'd0, 4'b0000, 4'b0000, 1'b1};  // r0
                default: ;
            endcase
        end
        return e;
    endfunction

    // Descending-address elements.
    function automatic logic elem_dn(input logic [1:0] mode, input logic [2:0] idx);
        case (mode)
            2'd0:    return idx == 3'd2;
            2'd1:    return (idx == 3'd3) || (idx == 3'd4);
            default: return idx == 3'd1;
        endcase
    endfunction

    state_t            r_state, w_state_nx;
    logic [1:0]        r_mode, w_mode_nx;
    logic              r_bg, w_bg_nx;
    logic [2:0]        r_elem, w_elem_nx;
    logic [1:0]        r_op, w_op_nx;
    logic [LAT_W-1:0]  r_lat, w_lat_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_fail, w_fail_nx;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nx;
    logic [2:0]        r_fail_elem, w_fail_elem_nx;

    elem_t             w_rom;
    logic              w_dn, w_ndn, w_is_wr, w_rd_end, w_op_end, w_mis, w_last_addr;
    logic [DATA_W-1:0] w_bg, w_exp;

    always_comb begin
        w_rom       = elem_rom(r_mode, r_elem);
        w_dn        = elem_dn(r_mode, r_elem);
        w_ndn       = elem_dn(r_mode, r_elem + 3'd1);
        w_is_wr     = w_rom.wr[r_op];
        w_bg        = r_bg ? (r_addr[0] ? ~CHK : CHK) : '0;
        w_exp       = w_rom.val[r_op] ? ~w_bg : w_bg;
        // Read data is compared in the last cycle of the read op.
        w_rd_end    = !w_is_wr && (r_lat == LAT_MAX);
        w_op_end    = w_is_wr || w_rd_end;
        w_mis       = (r_state == S_OP) && w_rd_end && (dat_in != w_exp);
        w_last_addr = w_dn ? (r_addr == '0) : (r_addr == '1);
    end

    always_comb begin
        w_state_nx     = r_state;
        w_mode_nx      = r_mode;
        w_bg_nx        = r_bg;
        w_elem_nx      = r_elem;
        w_op_nx        = r_op;
        w_lat_nx       = r_lat;
        w_addr_nx      = r_addr;
        w_fail_nx      = r_fail;
        w_fail_addr_nx = r_fail_addr;
        w_fail_elem_nx = r_fail_elem;
        case (r_state)
            S_IDLE: begin
                if (en_in) begin
                    w_state_nx     = S_OP;
                    w_mode_nx      = mode_in;
                    w_bg_nx        = bg_in;
                    w_elem_nx      = '0;
                    w_op_nx        = '0;
                    w_lat_nx       = '0;
                    w_addr_nx      = '0;  // element 0 always ascends
                    w_fail_nx      = 1'b0;
                    w_fail_addr_nx = '0;
                    w_fail_elem_nx = '0;
                end
            end
            S_OP: begin
                if (!w_op_end) begin
                    w_lat_nx = r_lat + 1'b1;
                end else begin
                    w_lat_nx = '0;
                    if (r_op != w_rom.nm1) begin
                        w_op_nx = r_op + 2'd1;
                    end else begin
                        w_op_nx = '0;
                        if (!w_last_addr)
                            w_addr_nx = w_dn ? r_addr - 1'b1 : r_addr + 1'b1;
                        else if (w_rom.last)
                            w_state_nx = S_DONE;
                        else begin
                            w_elem_nx = r_elem + 3'd1;
                            w_addr_nx = w_ndn ? '1 : '0;
                        end
                    end
                end
                if (w_mis) begin
                    w_fail_nx = 1'b1;
                    if (!r_fail) begin
                        w_fail_addr_nx = r_addr;
                        w_fail_elem_nx = r_elem;
                    end
                    if (STOP_ON_FAIL != 0) w_state_nx = S_DONE;
                end
            end
            S_DONE:  if (!en_in) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_bg        <= 1'b0;
            r_elem      <= '0;
            r_op        <= '0;
            r_lat       <= '0;
            r_addr      <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_mode      <= w_mode_nx;
            r_bg        <= w_bg_nx;
            r_elem      <= w_elem_nx;
            r_op        <= w_op_nx;
            r_lat       <= w_lat_nx;
            r_addr      <= w_addr_nx;
            r_fail      <= w_fail_nx;
            r_fail_addr <= w_fail_addr_nx;
            r_fail_elem <= w_fail_elem_nx;
        end
    end

    // Strobes decode from state so reset removes them without a clock.
    assign addr_out  = r_addr;
    assign dat_out   = (r_state == S_OP) ? w_exp : '0;
    assign w_en_out  = (r_state == S_OP) && w_is_wr;
    assign busy      = (r_state == S_OP);
    assign rst_done  = (r_state == S_DONE);
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_march_bist_engine.sv
module tb_march_bist_engine;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int RL = 2;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    en;
    logic [1:0]    mode_in;
    logic          bg_in;
    logic [DW-1:0] din    [2];
    logic [DW-1:0] dout   [2];
    logic [AW-1:0] addr_o [2];
    logic [AW-1:0] faddr_o[2];
    logic [2:0]    felem_o[2];
    logic          we_o [2], busy_o [2], done_o [2], fail_o [2];

    march_bist_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .STOP_ON_FAIL(0)) u_dut0 (
        .clk(clk), .rst(rst), .en_in(en[0]), .mode_in(mode_in), .bg_in(bg_in),
        .dat_in(din[0]), .addr_out(addr_o[0]), .dat_out(dout[0]), .w_en_out(we_o[0]),
        .busy(busy_o[0]), .rst_done(done_o[0]), .fail(fail_o[0]),
        .fail_addr(faddr_o[0]), .fail_elem(felem_o[0]));

    march_bist_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .STOP_ON_FAIL(1)) u_dut1 (
        .clk(clk), .rst(rst), .en_in(en[1]), .mode_in(mode_in), .bg_in(bg_in),
        .dat_in(din[1]), .addr_out(addr_o[1]), .dat_out(dout[1]), .w_en_out(we_o[1]),
        .busy(busy_o[1]), .rst_done(done_o[1]), .fail(fail_o[1]),
        .fail_addr(faddr_o[1]), .fail_elem(felem_o[1]));

    // SRAM models with an optional single stuck-at bit on the read path.
    logic          flt_en;
    int            flt_a, flt_b;
    logic          flt_v;
    logic [DW-1:0] mem [2][N];
    logic [DW-1:0] rdp [2][RL];

    function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (flt_en && a == flt_a) r[flt_b] = flt_v;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (we_o[g]) mem[g][addr_o[g]] <= dout[g];
            rdp[g][0] <= rd_fault(mem[g][addr_o[g]], int'(addr_o[g]));
            for (int k = 1; k < RL; k++) rdp[g][k] <= rdp[g][k-1];
        end
    end
    assign din[0] = rdp[0][RL-1];
    assign din[1] = rdp[1][RL-1];

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference model: expands the algorithm text into a per-cycle bus trace.
    int            xa[$];
    bit            xw[$];
    logic [DW-1:0] xd[$];
    logic [DW-1:0] xm [N];
    bit            xfail;
    int            xfa, xfe;

    function automatic logic [DW-1:0] bgv(input int a, input bit bg);
        logic [DW-1:0] b;
        for (int j = 0; j < DW; j++) b[j] = bg & (j[0] ^ a[0]);
        return b;
    endfunction

    task automatic build_model(input int mode, input bit bg, input bit stop);
        string alg[6];
        int    ne;
        bit    halt;
        halt = 0;
        xa.delete(); xw.delete(); xd.delete();
        xfail = 0; xfa = 0; xfe = 0;
        for (int i = 0; i < N; i++) xm[i] = '0;
        if (mode == 0) begin
            alg[0] = "Uw0"; alg[1] = "Ur0w1"; alg[2] = "Dr1w0"; ne = 3;
        end else if (mode == 1) begin
            alg[0] = "Uw0"; alg[1] = "Ur0w1"; alg[2] = "Ur1w0";
            alg[3] = "Dr0w1"; alg[4] = "Dr1w0"; alg[5] = "Ur0"; ne = 6;
        end else begin
            alg[0] = "Uw0"; alg[1] = "Dr0w1"; alg[2] = "Ur1w0r0w1";
            alg[3] = "Ur1w0"; alg[4] = "Ur0w1r1w0"; alg[5] = "Ur0"; ne = 6;
        end
        for (int e = 0; e < ne && !halt; e++) begin
            string s;
            s = alg[e];
            for (int i = 0; i < N && !halt; i++) begin
                int a;
                a = (s[0] == "D") ? N - 1 - i : i;
                for (int p = 1; p < s.len() && !halt; p += 2) begin
                    logic [DW-1:0] d;
                    d = (s[p+1] == "1") ? ~bgv(a, bg) : bgv(a, bg);
                    if (s[p] == "w") begin
                        xa.push_back(a); xw.push_back(1); xd.push_back(d);
                        xm[a] = d;
                    end else begin
                        for (int k = 0; k <= RL; k++) begin
                            xa.push_back(a); xw.push_back(0); xd.push_back(d);
                        end
                        if (rd_fault(xm[a], a) != d) begin
                            if (!xfail) begin xfail = 1; xfa = a; xfe = e; end
                            if (stop) halt = 1;
                        end
                    end
                end
            end
        end
    endtask

    // Follows one run from its start edge and compares it to the model.
    task automatic observe(input int sel, output int ncyc, output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        int    bad, mb;
        bit    to;
        string where;
        bad = 0; mb = 0; to = 1; where = ""; ncyc = 0; d0 = '0; d1 = '0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                mode_in = 2'($urandom);
                bg_in   = 1'($urandom);
            end
            if (!busy_o[sel]) begin to = 0; break; end
            if (ncyc >= xa.size() || addr_o[sel] !== AW'(xa[ncyc]) ||
                we_o[sel] !== xw[ncyc] || dout[sel] !== xd[ncyc]) begin
                if (bad == 0)
                    where = $sformatf("cyc%0d a=%0h we=%0b d=%0h", ncyc, addr_o[sel], we_o[sel], dout[sel]);
                bad++;
            end
            if (ncyc == 0) d0 = dout[sel];
            if (ncyc == 1) d1 = dout[sel];
            ncyc++;
        end
        check("timeout", 32'(to), 0);
        check({"trace ", where}, bad, 0);
        check("cycles", ncyc, xa.size());
        check("rst_done", 32'(done_o[sel]), 1);
        check("fail", 32'(fail_o[sel]), 32'(xfail));
        check("fail_addr", 32'(faddr_o[sel]), xfa);
        check("fail_elem", 32'(felem_o[sel]), xfe);
        for (int i = 0; i < N; i++) if (mem[sel][i] !== xm[i]) mb++;
        check("memory", mb, 0);
    endtask

    task automatic run(input int sel, input int mode, input bit bg,
                       output int ncyc, output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        build_model(mode, bg, sel == 1);
        mode_in = 2'(mode);
        bg_in   = bg;
        en[sel] = 1'b1;
        observe(sel, ncyc, d0, d1);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(done_o[sel]), 1);
        check("we_in_done", 32'(we_o[sel]), 0);
        en[sel] = 1'b0;
        @(posedge clk); #1;
        check("back_idle", 32'(done_o[sel]), 0);
    endtask

    typedef struct {
        int            sel, mode;
        bit            bg, fen;
        int            fa, fb;
        bit            fv;
        int            cyc;
        bit            fail;
        int            faddr, felem;
        logic [DW-1:0] d0, d1;
    } vec_t;

    initial begin
        vec_t          tbl[6];
        int            ncyc;
        logic [DW-1:0] d0, d1;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 144, 0, 0, 0, 4'h0, 4'h0};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 320, 0, 0, 0, 4'h0, 4'h0};
        tbl[2] = '{0, 2, 0, 0, 0, 0, 0, 448, 0, 0, 0, 4'h0, 4'h0};
        tbl[3] = '{0, 2, 1, 0, 0, 0, 0, 448, 0, 0, 0, 4'hA, 4'h5};
        tbl[4] = '{0, 1, 0, 1, 5, 2, 1, 320, 1, 5, 1, 4'h0, 4'h0};
        tbl[5] = '{1, 1, 0, 1, 5, 2, 1,  39, 1, 5, 1, 4'h0, 4'h0};

        en = '0; mode_in = '0; bg_in = 1'b0; flt_en = 1'b0; flt_a = 0; flt_b = 0; flt_v = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_addr", 32'(addr_o[g]), 0);
            check("rst_dat", 32'(dout[g]), 0);
            check("rst_we", 32'(we_o[g]), 0);
            check("rst_busy", 32'(busy_o[g]), 0);
            check("rst_done_r", 32'(done_o[g]), 0);
            check("rst_fail", 32'(fail_o[g]), 0);
            check("rst_faddr", 32'(faddr_o[g]), 0);
            check("rst_felem", 32'(felem_o[g]), 0);
        end
        #20 rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            flt_en = tbl[t].fen; flt_a = tbl[t].fa; flt_b = tbl[t].fb; flt_v = tbl[t].fv;
            run(tbl[t].sel, tbl[t].mode, tbl[t].bg, ncyc, d0, d1);
            check($sformatf("t%0d cycles", t), ncyc, tbl[t].cyc);
            check($sformatf("t%0d fail", t), 32'(fail_o[tbl[t].sel]), 32'(tbl[t].fail));
            check($sformatf("t%0d fail_addr", t), 32'(faddr_o[tbl[t].sel]), tbl[t].faddr);
            check($sformatf("t%0d fail_elem", t), 32'(felem_o[tbl[t].sel]), tbl[t].felem);
            check($sformatf("t%0d first_wr", t), 32'(d0), 32'(tbl[t].d0));
            check($sformatf("t%0d second_wr", t), 32'(d1), 32'(tbl[t].d1));
        end
        flt_en = 1'b0;

        // Reset in the middle of a March LR run, with en_in held high.
        build_model(2, 0, 0);
        mode_in = 2'd2; bg_in = 1'b0; en[0] = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        for (int k = 0; k < 8 && !we_o[0]; k++) begin @(posedge clk); #1; end
        check("pre_rst_we", 32'(we_o[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", 32'(we_o[0]), 0);
        check("arst_busy", 32'(busy_o[0]), 0);
        check("arst_addr", 32'(addr_o[0]), 0);
        check("arst_dat", 32'(dout[0]), 0);
        check("arst_done", 32'(done_o[0]), 0);
        @(posedge clk); #1;
        check("arst_hold", 32'(busy_o[0]), 0);
        rst = 1'b0;
        observe(0, ncyc, d0, d1);
        check("rerun_cycles", ncyc, 448);
        en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random configurations and faults against the model.
        for (int r = 0; r < 12; r++) begin
            int sel, mode;
            bit bg;
            sel    = $urandom_range(0, 1);
            mode   = $urandom_range(0, 3);
            bg     = 1'($urandom);
            flt_en = 1'($urandom);
            flt_a  = $urandom_range(0, N - 1);
            flt_b  = $urandom_range(0, DW - 1);
            flt_v  = 1'($urandom);
            run(sel, mode, bg, ncyc, d0, d1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000");
        $fatal(1, "watchdog");
    end
endmodule
